// File: rtl/sqrt_arb_pkg.sv
// Shared helpers for the sqrt LUT arbiter: round-robin grant selection.
package sqrt_arb_pkg;

    localparam int MAX_REQ = 32;

    // One-hot grant of the first eligible lane at or after ptr, searching circularly over n_req lanes.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0] eligible,
        input int unsigned        ptr,
        input int unsigned        n_req
    );
        logic [MAX_REQ-1:0] grant;
        logic               found;
        int unsigned        idx;
        grant = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            idx = (ptr + i) % n_req;
            if (i < n_req && !found && eligible[idx[4:0]]) begin
                grant[idx[4:0]] = 1'b1;
                found           = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/sqrt_arb_tag_fifo.sv
// In-order tag queue: remembers which lane each outstanding sqrt lookup belongs to.
module sqrt_arb_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_tag,
    input  logic         i_pop,
    output logic [W-1:0] o_tag,
    output logic         o_empty,
    output logic         o_full
);
    localparam int W_PTR = $clog2(DEPTH);
    localparam int W_CNT = $clog2(DEPTH + 1);

    logic [W-1:0]     r_mem [DEPTH];
    logic [W_PTR-1:0] r_wr_ptr;
    logic [W_PTR-1:0] r_rd_ptr;
    logic [W_CNT-1:0] r_count;

    // NOTE: storage carries no reset; only pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= (r_wr_ptr == W_PTR'(DEPTH - 1)) ? '0 : r_wr_ptr + W_PTR'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= (r_rd_ptr == W_PTR'(DEPTH - 1)) ? '0 : r_rd_ptr + W_PTR'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + W_CNT'(1);
                2'b01:   r_count <= r_count - W_CNT'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Head is read from the registered array, so a same-cycle push never falls through.
    assign o_tag   = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == W_CNT'(DEPTH));

endmodule

// File: rtl/sqrt_lut_arbiter.sv
// Shares one in-order sqrt lookup memory among N_REQ lanes with round-robin grants.
module sqrt_lut_arbiter
    import sqrt_arb_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int W_ADDR = 8,
    parameter int W_DATA = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ*W_ADDR-1:0]   req_addr,
    output logic [N_REQ-1:0]          resp_valid,
    input  logic [N_REQ-1:0]          resp_ready,
    output logic [N_REQ*W_DATA-1:0]   resp_data,
    output logic                      mem_addr_valid,
    input  logic                      mem_addr_ready,
    output logic [W_ADDR-1:0]         mem_addr_data,
    input  logic                      mem_data_valid,
    output logic                      mem_data_ready,
    input  logic [W_DATA-1:0]         mem_data,
    output logic                      protocol_err
);
    localparam int W_TAG = $clog2(N_REQ);

    logic [N_REQ-1:0]        r_busy;
    logic [N_REQ-1:0]        r_resp_valid;
    logic [N_REQ*W_DATA-1:0] r_resp_data;
    logic [W_TAG-1:0]        r_rr_ptr;
    logic                    r_protocol_err;

    logic [N_REQ-1:0]   w_eligible;
    logic [N_REQ-1:0]   w_grant;
    logic [N_REQ-1:0]   w_resp_hs;
    logic [MAX_REQ-1:0] w_elig_ext;
    logic [W_TAG-1:0]   w_grant_idx;
    logic [W_TAG-1:0]   w_tag_head;
    logic [W_ADDR-1:0]  w_addr;
    logic               w_push;
    logic               w_pop;
    logic               w_fifo_empty;
    logic               w_fifo_full;

    assign w_eligible = req_valid & ~r_busy;
    assign w_resp_hs  = r_resp_valid & resp_ready;

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        w_elig_ext              = '0;
        w_elig_ext[N_REQ-1:0]   = w_eligible;
        w_grant                 = N_REQ'(rr_pick(w_elig_ext, 32'(r_rr_ptr), N_REQ));
        w_grant_idx             = '0;
        w_addr                  = '0;
        for (int r = 0; r < N_REQ; r++) begin
            if (w_grant[r]) begin
                w_grant_idx = W_TAG'(r);
                w_addr      = req_addr[r*W_ADDR +: W_ADDR];
            end
        end
    end

    assign mem_addr_valid = |w_eligible;
    assign mem_addr_data  = w_addr;
    assign req_ready      = w_grant & {N_REQ{mem_addr_ready}};
    assign mem_data_ready = 1'b1;
    assign w_push         = mem_addr_valid & mem_addr_ready;
    assign w_pop          = mem_data_valid & ~w_fifo_empty;

    sqrt_arb_tag_fifo #(
        .DEPTH (N_REQ),
        .W     (W_TAG)
    ) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_tag   (w_grant_idx),
        .i_pop   (w_pop),
        .o_tag   (w_tag_head),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy         <= '0;
            r_rr_ptr       <= '0;
            r_resp_valid   <= '0;
            r_resp_data    <= '0;
            r_protocol_err <= 1'b0;
        end else begin
            // A lane cannot be set and cleared together: set needs ~busy, clear needs a held result.
            r_busy <= (r_busy & ~w_resp_hs) | req_ready;
            if (w_push) begin
                r_rr_ptr <= (w_grant_idx == W_TAG'(N_REQ - 1)) ? '0 : w_grant_idx + W_TAG'(1);
            end
            if (mem_data_valid && w_fifo_empty) begin
                r_protocol_err <= 1'b1;
            end
            for (int r = 0; r < N_REQ; r++) begin
                if (w_resp_hs[r]) begin
                    r_resp_valid[r] <= 1'b0;
                end
                if (w_pop && (w_tag_head == W_TAG'(r))) begin
                    r_resp_valid[r]                 <= 1'b1;
                    r_resp_data[r*W_DATA +: W_DATA] <= mem_data;
                end
            end
        end
    end

    assign resp_valid   = r_resp_valid;
    assign resp_data    = r_resp_data;
    assign protocol_err = r_protocol_err;

    // The busy bits bound outstanding tags to N_REQ, so the queue can never overflow.
    a_tag_fifo_no_overflow: assert property (@(posedge clk) disable iff (rst) !(w_push && w_fifo_full));

endmodule

// File: tb/tb_sqrt_lut_arbiter.sv
// Directed bench for sqrt_lut_arbiter: grant vectors plus multi-cycle handshake sequences.
module tb_sqrt_lut_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready;
    logic [31:0] req_addr = '0;
    logic [3:0]  resp_valid;
    logic [3:0]  resp_ready = '0;
    logic [63:0] resp_data;
    logic        mem_addr_valid;
    logic        mem_addr_ready = 1'b1;
    logic [7:0]  mem_addr_data;
    logic        mem_data_valid = 1'b0;
    logic        mem_data_ready;
    logic [15:0] mem_data = '0;
    logic        protocol_err;

    int   n_cmp = 0;
    int   n_err = 0;
    logic auto_mem = 1'b0;
    logic [7:0] lane_addr [4] = '{8'h40, 8'h51, 8'h10, 8'h73};

    typedef struct {
        logic [3:0] req_valid;
        logic       mem_ready;
        logic [3:0] exp_ready;
        logic       exp_mav;
        logic [7:0] exp_addr;
    } vec_t;
    vec_t vecs [8];

    sqrt_lut_arbiter #(.N_REQ(4), .W_ADDR(8), .W_DATA(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_data      (resp_data),
        .mem_addr_valid (mem_addr_valid),
        .mem_addr_ready (mem_addr_ready),
        .mem_addr_data  (mem_addr_data),
        .mem_data_valid (mem_data_valid),
        .mem_data_ready (mem_data_ready),
        .mem_data       (mem_data),
        .protocol_err   (protocol_err)
    );

    always #10 clk = ~clk;

    // Memory contents seen by the bench: a fixed tag in the upper byte plus the address.
    function automatic logic [15:0] sq(input logic [7:0] a);
        return {8'hC3, a};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // One clock: models a memory that answers every accepted address one cycle later.
    task automatic tick();
        logic        pv;
        logic [15:0] pd;
        #1;
        pv = auto_mem && !rst && mem_addr_valid && mem_addr_ready;
        pd = sq(mem_addr_data);
        @(posedge clk);
        #1;
        if (auto_mem) begin
            mem_data_valid = pv;
            mem_data       = pd;
        end
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        req_valid      = '0;
        resp_ready     = '0;
        mem_addr_ready = 1'b1;
        mem_data_valid = 1'b0;
        auto_mem       = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int exp_c [15];
        int lane;

        for (int r = 0; r < 4; r++) req_addr[r*8 +: 8] = lane_addr[r];

        vecs[0] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00};
        vecs[1] = '{4'b0001, 1'b1, 4'b0001, 1'b1, 8'h40};
        vecs[2] = '{4'b0100, 1'b1, 4'b0100, 1'b1, 8'h10};
        vecs[3] = '{4'b1100, 1'b1, 4'b0100, 1'b1, 8'h10};
        vecs[4] = '{4'b1010, 1'b1, 4'b0010, 1'b1, 8'h51};
        vecs[5] = '{4'b1111, 1'b1, 4'b0001, 1'b1, 8'h40};
        vecs[6] = '{4'b1000, 1'b1, 4'b1000, 1'b1, 8'h73};
        vecs[7] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 8'h40};

        // Reset state
        do_reset();
        #1;
        check("rst resp_valid", 32'(resp_valid), 32'h0);
        check("rst resp_data", resp_data[31:0] | resp_data[63:32], 32'h0);
        check("rst protocol_err", 32'(protocol_err), 32'h0);
        check("rst mem_data_ready", 32'(mem_data_ready), 32'h1);
        check("rst mem_addr_valid", 32'(mem_addr_valid), 32'h0);

        // Grant vectors from the reset state (rr_ptr=0, no lane busy); no clock edge passes
        for (int i = 0; i < 8; i++) begin
            req_valid      = vecs[i].req_valid;
            mem_addr_ready = vecs[i].mem_ready;
            #1;
            check($sformatf("vec%0d req_ready", i), 32'(req_ready), 32'(vecs[i].exp_ready));
            check($sformatf("vec%0d mem_addr_valid", i), 32'(mem_addr_valid), 32'(vecs[i].exp_mav));
            if (vecs[i].exp_mav)
                check($sformatf("vec%0d mem_addr_data", i), 32'(mem_addr_data), 32'(vecs[i].exp_addr));
        end
        req_valid      = '0;
        mem_addr_ready = 1'b1;

        // Single lane: lane 2, memory answers 0x0004 one cycle after the address
        do_reset();
        req_valid = 4'b0100;
        #1;
        check("A req_ready", 32'(req_ready), 32'b0100);
        check("A mem_addr_data", 32'(mem_addr_data), 32'h10);
        tick();
        req_valid      = '0;
        mem_data_valid = 1'b1;
        mem_data       = 16'h0004;
        #1;
        check("A resp_valid early", 32'(resp_valid), 32'h0);
        tick();
        mem_data_valid = 1'b0;
        req_valid      = 4'b0100;
        #1;
        check("A resp_valid", 32'(resp_valid), 32'b0100);
        check("A resp_data", 32'(resp_data[32 +: 16]), 32'h0004);
        check("A busy blocks req", 32'(req_ready), 32'h0);
        check("A busy blocks mem", 32'(mem_addr_valid), 32'h0);
        tick();
        #1;
        check("A resp hold valid", 32'(resp_valid), 32'b0100);
        check("A resp hold data", 32'(resp_data[32 +: 16]), 32'h0004);
        resp_ready = 4'b0100;
        #1;
        check("A busy in resp hs cycle", 32'(req_ready), 32'h0);
        tick();
        #1;
        check("A resp_valid cleared", 32'(resp_valid), 32'h0);
        check("A eligible after hs", 32'(req_ready), 32'b0100);
        req_valid  = '0;
        resp_ready = '0;
        tick();

        // All lanes requesting, all consumers ready: grants 0,1,2,3,0,... every cycle
        do_reset();
        req_valid  = 4'b1111;
        resp_ready = 4'b1111;
        auto_mem   = 1'b1;
        for (int c = 0; c < 16; c++) begin
            #1;
            check($sformatf("B c%0d grant", c), 32'(req_ready), 32'(1) << (c % 4));
            if (c >= 2) begin
                lane = (c - 2) % 4;
                check($sformatf("B c%0d resp_valid", c), 32'(resp_valid), 32'(1) << lane);
                check($sformatf("B c%0d resp_data", c), 32'(resp_data[lane*16 +: 16]), 32'(sq(lane_addr[lane])));
            end else begin
                check($sformatf("B c%0d resp_valid", c), 32'(resp_valid), 32'h0);
            end
            tick();
        end

        // Lane 1 stalls its consumer; others keep one grant per cycle
        do_reset();
        exp_c      = '{0, 1, 2, 3, 0, 2, 3, 0, 2, 3, 0, 2, 3, 0, 1};
        req_valid  = 4'b1111;
        resp_ready = 4'b1101;
        auto_mem   = 1'b1;
        for (int c = 0; c < 15; c++) begin
            if (c == 13) resp_ready = 4'b1111;
            #1;
            check($sformatf("C c%0d grant", c), 32'(req_ready), 32'(1) << exp_c[c]);
            if (c >= 3 && c <= 13) begin
                check($sformatf("C c%0d lane1 valid", c), 32'(resp_valid[1]), 32'h1);
                check($sformatf("C c%0d lane1 data", c), 32'(resp_data[16 +: 16]), 32'(sq(8'h51)));
            end
            if (c == 14)
                check("C lane1 valid after hs", 32'(resp_valid[1]), 32'h0);
            tick();
        end

        // Address stall: rr_ptr wraps 3->0, then holds through 5 stalled cycles
        do_reset();
        auto_mem   = 1'b1;
        resp_ready = 4'b1111;
        req_valid  = 4'b1000;
        #1;
        check("D lane3 grant", 32'(req_ready), 32'b1000);
        tick();
        req_valid = '0;
        tick();
        tick();
        req_valid      = 4'b1001;
        mem_addr_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            check($sformatf("D stall%0d req_ready", c), 32'(req_ready), 32'h0);
            check($sformatf("D stall%0d addr", c), 32'(mem_addr_data), 32'h40);
            tick();
        end
        mem_addr_ready = 1'b1;
        #1;
        check("D first ready grant", 32'(req_ready), 32'b0001);
        req_valid = '0;
        tick();

        // Orphan memory response, then reset in the middle of traffic
        do_reset();
        mem_data_valid = 1'b1;
        mem_data       = 16'hBEEF;
        #1;
        check("E err before edge", 32'(protocol_err), 32'h0);
        tick();
        mem_data_valid = 1'b0;
        #1;
        check("E protocol_err", 32'(protocol_err), 32'h1);
        check("E no resp_valid", 32'(resp_valid), 32'h0);
        tick();
        #1;
        check("E protocol_err sticky", 32'(protocol_err), 32'h1);
        auto_mem   = 1'b1;
        resp_ready = 4'b0000;
        req_valid  = 4'b1111;
        tick();
        tick();
        tick();
        #1;
        check("E pre-reset resp_valid", 32'(resp_valid), 32'b0011);
        rst = 1'b1;
        tick();
        #1;
        check("E reset resp_valid", 32'(resp_valid), 32'h0);
        check("E reset resp_data", resp_data[31:0] | resp_data[63:32], 32'h0);
        check("E reset protocol_err", 32'(protocol_err), 32'h0);
        rst = 1'b0;
        #1;
        check("E post-reset grant", 32'(req_ready), 32'b0001);
        tick();
        tick();
        #1;
        check("E post-reset resp_valid", 32'(resp_valid), 32'b0001);
        check("E post-reset resp_data", 32'(resp_data[15:0]), 32'(sq(8'h40)));
        req_valid = '0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
